// File: rtl/pipe_run_controller.sv
// pipe_run_controller
//   Run/step/halt sequencer for a simple pipelined core. It gates the
//   PC/pipeline-latch enable, counts executed (enabled) cycles, drains the
//   pipeline for a fixed number of cycles once a halt instruction reaches
//   IF/ID, and issues a one-cycle program-reset pulse on request.
//
// Ports
//   i_clk          clock, all state on rising edge
//   i_rst          asynchronous active-high reset
//   i_cmd_valid    command present
//   i_cmd_op       00 RUN, 01 STEP, 10 STOP, 11 PROG_RESET
//   i_step_count   cycles to execute for STEP (0 is treated as 1)
//   i_halt_id      halt instruction present in IF/ID
//   i_load_busy    instruction memory write in progress (pauses execution)
//   o_cmd_ready    command accepted when i_cmd_valid && o_cmd_ready
//   o_pipe_en      enable for PC and pipeline latches
//   o_prog_reset   one-cycle program reset pulse (registered)
//   o_done         one-cycle completion pulse (registered)
//   o_state        current FSM state
//   o_cycle_count  enabled cycles since last program reset (saturating)
module pipe_run_controller #(
    parameter int DRAIN_CYCLES = 4,
    parameter int COUNT_W      = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_cmd_valid,
    input  logic [1:0]         i_cmd_op,
    input  logic [7:0]         i_step_count,
    input  logic               i_halt_id,
    input  logic               i_load_busy,
    output logic               o_cmd_ready,
    output logic               o_pipe_en,
    output logic               o_prog_reset,
    output logic               o_done,
    output logic [2:0]         o_state,
    output logic [COUNT_W-1:0] o_cycle_count
);

    // Wide enough to hold DRAIN_CYCLES, never zero bits wide.
    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_STEP   = 3'd2,
        S_DRAIN  = 3'd3,
        S_HALTED = 3'd4,
        S_PRESET = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        OP_RUN        = 2'b00,
        OP_STEP       = 2'b01,
        OP_STOP       = 2'b10,
        OP_PROG_RESET = 2'b11
    } cmd_t;

    state_t               state_q, state_d;
    logic [7:0]           step_q, step_d;
    logic [DRAIN_W-1:0]   drain_q, drain_d;
    logic [COUNT_W-1:0]   count_q;
    logic                 done_d, prog_d;
    logic                 accept;
    cmd_t                 op;

    assign op = cmd_t'(i_cmd_op);

    // Load-busy freezes everything: no enable, no command acceptance.
    assign o_pipe_en   = !i_load_busy &&
                         (state_q == S_RUN || state_q == S_STEP || state_q == S_DRAIN);
    assign o_cmd_ready = !i_load_busy &&
                         (state_q == S_IDLE || state_q == S_RUN || state_q == S_HALTED);
    assign accept      = i_cmd_valid && o_cmd_ready;

    assign o_state       = state_q;
    assign o_cycle_count = count_q;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_d = state_q;
        step_d  = step_q;
        drain_d = drain_q;
        done_d  = 1'b0;
        prog_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (op)
                        OP_RUN:  state_d = S_RUN;
                        OP_STEP: begin
                            state_d = S_STEP;
                            step_d  = (i_step_count == 8'd0) ? 8'd1 : i_step_count;
                        end
                        OP_PROG_RESET: begin
                            state_d = S_PRESET;
                            prog_d  = 1'b1;
                        end
                        default: ;  // STOP while idle has nothing to stop
                    endcase
                end
            end

            S_RUN: begin
                // Halt wins over a STOP presented in the same cycle.
                if (o_pipe_en && i_halt_id) begin
                    state_d = S_DRAIN;
                    drain_d = DRAIN_W'(DRAIN_CYCLES);
                end else if (accept && op == OP_STOP) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end

            S_STEP: begin
                if (o_pipe_en) begin
                    step_d = step_q - 8'd1;
                    // Halt wins over finishing the last step.
                    if (i_halt_id) begin
                        state_d = S_DRAIN;
                        drain_d = DRAIN_W'(DRAIN_CYCLES);
                    end else if (step_q <= 8'd1) begin
                        state_d = S_IDLE;
                        step_d  = 8'd0;
                        done_d  = 1'b1;
                    end
                end
            end

            S_DRAIN: begin
                if (o_pipe_en) begin
                    if (drain_q <= DRAIN_W'(1)) begin
                        state_d = S_HALTED;
                        drain_d = '0;
                        done_d  = 1'b1;
                    end else begin
                        drain_d = drain_q - DRAIN_W'(1);
                    end
                end
            end

            S_HALTED: begin
                if (accept && op == OP_PROG_RESET) begin
                    state_d = S_PRESET;
                    prog_d  = 1'b1;
                end
            end

            S_PRESET: state_d = S_IDLE;

            default:  state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            // NOTE: all counters are explicitly reset; an aborted STEP or
            // DRAIN must not leave a stale count behind for the next run.
            state_q      <= S_IDLE;
            step_q       <= '0;
            drain_q      <= '0;
            count_q      <= '0;
            o_done       <= 1'b0;
            o_prog_reset <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            drain_q      <= drain_d;
            o_done       <= done_d;
            o_prog_reset <= prog_d;
            // Clear coincides with entering PRESET; pipe_en is never high
            // in the states that can issue it, so there is no conflict.
            if (prog_d) begin
                count_q <= '0;
            end else if (o_pipe_en && !(&count_q)) begin
                count_q <= count_q + COUNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_run_controller.sv
// Testbench for pipe_run_controller. Directed stimulus pushes the expected
// completion / program-reset events into a queue; a monitor pops one entry
// whenever the DUT pulses o_done or o_prog_reset and compares it. Static
// properties (reset values, busy behaviour, saturation) are checked inline.
module tb_pipe_run_controller;

    localparam logic [1:0] OP_RUN        = 2'b00;
    localparam logic [1:0] OP_STEP       = 2'b01;
    localparam logic [1:0] OP_STOP       = 2'b10;
    localparam logic [1:0] OP_PROG_RESET = 2'b11;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_cmd_valid;
    logic [1:0]  i_cmd_op;
    logic [7:0]  i_step_count;
    logic        i_halt_id;
    logic        i_load_busy;

    logic        o_cmd_ready, o_pipe_en, o_prog_reset, o_done;
    logic [2:0]  o_state;
    logic [31:0] o_cycle_count;

    // Narrow-counter instance sharing the same stimulus, for saturation.
    logic        sat_cmd_ready, sat_pipe_en, sat_prog_reset, sat_done;
    logic [2:0]  sat_state;
    logic [2:0]  sat_cycle_count;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        string       name;
        logic [2:0]  state;
        logic [31:0] count;
        logic        done;
        logic        prog;
        int          en_cycles;  // enabled cycles since previous event
    } ev_t;

    ev_t exp_q[$];

    pipe_run_controller dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_cmd_valid   (i_cmd_valid),
        .i_cmd_op      (i_cmd_op),
        .i_step_count  (i_step_count),
        .i_halt_id     (i_halt_id),
        .i_load_busy   (i_load_busy),
        .o_cmd_ready   (o_cmd_ready),
        .o_pipe_en     (o_pipe_en),
        .o_prog_reset  (o_prog_reset),
        .o_done        (o_done),
        .o_state       (o_state),
        .o_cycle_count (o_cycle_count)
    );

    pipe_run_controller #(.DRAIN_CYCLES(4), .COUNT_W(3)) dut_sat (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_cmd_valid   (i_cmd_valid),
        .i_cmd_op      (i_cmd_op),
        .i_step_count  (i_step_count),
        .i_halt_id     (i_halt_id),
        .i_load_busy   (i_load_busy),
        .o_cmd_ready   (sat_cmd_ready),
        .o_pipe_en     (sat_pipe_en),
        .o_prog_reset  (sat_prog_reset),
        .o_done        (sat_done),
        .o_state       (sat_state),
        .o_cycle_count (sat_cycle_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d, required %0d", name, act, exp);
    endtask

    task automatic expect_ev(input string name, input logic [2:0] st, input logic [31:0] cnt,
                             input logic done, input logic prog, input int en);
        ev_t e;
        e.name = name; e.state = st; e.count = cnt;
        e.done = done; e.prog = prog; e.en_cycles = en;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [7:0] n);
        i_cmd_valid  = 1'b1;
        i_cmd_op     = op;
        i_step_count = n;
        tick();
        i_cmd_valid  = 1'b0;
    endtask

    // Monitor: samples on the falling edge, pops on every event pulse.
    initial begin
        int  en_cnt;
        ev_t e;
        bit  ok;
        en_cnt = 0;
        forever begin
            @(negedge i_clk);
            if (i_rst) begin
                en_cnt = 0;
            end else begin
                if (o_done || o_prog_reset) begin
                    total_cnt++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL unexpected_event: got state=%0d done=%0b prog=%0b count=%0d, required no event",
                                 o_state, o_done, o_prog_reset, o_cycle_count);
                    end else begin
                        e  = exp_q.pop_front();
                        ok = (o_state == e.state) && (o_cycle_count == e.count) &&
                             (o_done == e.done) && (o_prog_reset == e.prog) &&
                             (o_pipe_en == 1'b0) && (en_cnt == e.en_cycles);
                        if (ok) pass_cnt++;
                        else $display("FAIL %s: got state=%0d count=%0d done=%0b prog=%0b pipe_en=%0b en_cycles=%0d, required state=%0d count=%0d done=%0b prog=%0b pipe_en=0 en_cycles=%0d",
                                      e.name, o_state, o_cycle_count, o_done, o_prog_reset, o_pipe_en, en_cnt,
                                      e.state, e.count, e.done, e.prog, e.en_cycles);
                    end
                    en_cnt = 0;
                end
                if (o_pipe_en) en_cnt++;
            end
        end
    end

    initial begin
        i_rst = 1'b1; i_cmd_valid = 1'b0; i_cmd_op = OP_RUN; i_step_count = 8'd0;
        i_halt_id = 1'b0; i_load_busy = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_state",      o_state, 0);
        check("rst_count",      o_cycle_count, 0);
        check("rst_done",       o_done, 0);
        check("rst_prog_reset", o_prog_reset, 0);
        check("rst_pipe_en",    o_pipe_en, 0);
        i_rst = 1'b0;
        #1;
        check("rst_cmd_ready",  o_cmd_ready, 1);

        // STOP while idle is ignored
        send(OP_STOP, 8'd0);
        check("idle_stop_ignored", o_state, 0);

        // STEP 3: three enabled cycles, then done in IDLE
        expect_ev("step3_done", 3'd0, 32'd3, 1'b1, 1'b0, 3);
        send(OP_STEP, 8'd3);
        check("step3_state", o_state, 2);
        repeat (6) tick();

        // STEP 0 behaves as STEP 1
        expect_ev("step0_done", 3'd0, 32'd4, 1'b1, 1'b0, 1);
        send(OP_STEP, 8'd0);
        repeat (4) tick();
        check("sat_count_4", sat_cycle_count, 4);

        // program reset from IDLE
        expect_ev("preset_idle", 3'd5, 32'd0, 1'b0, 1'b1, 0);
        send(OP_PROG_RESET, 8'd0);
        check("preset_state", o_state, 5);
        tick();
        check("preset_to_idle", o_state, 0);

        // RUN, halt on enabled cycle 10 (held into DRAIN, which ignores it)
        expect_ev("run_halt_done", 3'd4, 32'd14, 1'b1, 1'b0, 14);
        send(OP_RUN, 8'd0);
        repeat (9) tick();
        i_halt_id = 1'b1;
        tick();
        check("halt_enters_drain", o_state, 3);
        tick();
        i_halt_id = 1'b0;
        repeat (5) tick();
        check("halted_state",   o_state, 4);
        check("halted_pipe_en", o_pipe_en, 0);
        check("halted_count",   o_cycle_count, 14);
        check("sat_count_max",  sat_cycle_count, 7);

        // RUN is ignored in HALTED, then program reset
        send(OP_RUN, 8'd0);
        tick();
        check("halted_run_ignored", o_state, 4);
        expect_ev("preset_halted", 3'd5, 32'd0, 1'b0, 1'b1, 0);
        send(OP_PROG_RESET, 8'd0);
        tick();
        check("preset2_state", o_state, 0);
        check("preset2_prog",  o_prog_reset, 0);
        check("preset2_count", o_cycle_count, 0);

        // RUN paused by load_busy, then STOP
        expect_ev("run_stop_done", 3'd0, 32'd6, 1'b1, 1'b0, 6);
        send(OP_RUN, 8'd0);
        repeat (3) tick();
        i_load_busy = 1'b1;
        #1;
        check("busy_pipe_en",   o_pipe_en, 0);
        check("busy_cmd_ready", o_cmd_ready, 0);
        repeat (5) tick();
        check("busy_state", o_state, 1);
        check("busy_count", o_cycle_count, 3);
        i_load_busy = 1'b0;
        #1;
        check("resume_pipe_en", o_pipe_en, 1);
        repeat (2) tick();
        send(OP_STOP, 8'd0);
        check("stop_state", o_state, 0);

        // last STEP cycle coincides with halt: drain, no early done
        expect_ev("preset_b", 3'd5, 32'd0, 1'b0, 1'b1, 0);
        send(OP_PROG_RESET, 8'd0);
        tick();
        expect_ev("step_halt_drain_done", 3'd4, 32'd6, 1'b1, 1'b0, 6);
        send(OP_STEP, 8'd2);
        tick();
        i_halt_id = 1'b1;
        tick();
        i_halt_id = 1'b0;
        check("step_halt_drain", o_state, 3);
        check("step_halt_no_done", o_done, 0);
        repeat (5) tick();
        check("step_halt_halted", o_state, 4);

        // reset asserted mid-DRAIN aborts with no done
        expect_ev("preset_c", 3'd5, 32'd0, 1'b0, 1'b1, 0);
        send(OP_PROG_RESET, 8'd0);
        tick();
        send(OP_RUN, 8'd0);
        repeat (2) tick();
        i_halt_id = 1'b1;
        tick();
        i_halt_id = 1'b0;
        tick();
        check("mid_drain_state", o_state, 3);
        i_rst = 1'b1;
        #1;
        check("abort_state",   o_state, 0);
        check("abort_pipe_en", o_pipe_en, 0);
        check("abort_count",   o_cycle_count, 0);
        check("abort_done",    o_done, 0);
        check("abort_prog",    o_prog_reset, 0);
        tick();
        i_rst = 1'b0;
        #1;
        check("abort_cmd_ready", o_cmd_ready, 1);
        repeat (8) tick();
        check("abort_stays_idle", o_state, 0);
        check("abort_count_held", o_cycle_count, 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
